// File: rtl/game_sequencer_if.sv
// Sound request handshake between the game sequencer (master) and the sound player (slave).
interface game_sequencer_if;
   logic [1:0] sound_sel;
   logic       sound_valid;
   logic       sound_ready;

   modport master (output sound_sel, output sound_valid, input sound_ready);
   modport slave  (input sound_sel, input sound_valid, output sound_ready);
endinterface

// File: rtl/game_sequencer.sv
// Frogger-style game flow FSM: menu, play, death/level-up holds, win/game over, sound requests.
// Define GAME_SEQUENCER_PAUSE_EN to enable the PAUSED state (all four d-pad bits pressed).
module game_sequencer #(
   parameter int NUM_LEVELS  = 8,
   parameter int NUM_LIVES   = 3,
   parameter int HOLD_FRAMES = 60
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic [3:0]        dpad_input,
   input  logic              collision,
   input  logic              reached_end,
   output logic [2:0]        state,
   output logic [3:0]        level,
   output logic [2:0]        lives,
   output logic              win,
   output logic              lose,
   game_sequencer_if.master  snd
);

   localparam logic [2:0] S_MENU      = 3'd0;
   localparam logic [2:0] S_PLAYING   = 3'd1;
   localparam logic [2:0] S_DYING     = 3'd2;
   localparam logic [2:0] S_LEVEL_UP  = 3'd3;
   localparam logic [2:0] S_GAME_OVER = 3'd4;
   localparam logic [2:0] S_WIN       = 3'd5;
`ifdef GAME_SEQUENCER_PAUSE_EN
   localparam logic [2:0] S_PAUSED    = 3'd6;
`endif

   localparam logic [1:0] SND_UI_PRESS    = 2'd0;
   localparam logic [1:0] SND_NEXTLEVEL   = 2'd1;
   localparam logic [1:0] SND_CRASH       = 2'd2;
   localparam logic [1:0] SND_CELEBRATION = 2'd3;

   localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
   localparam logic [2:0] LIVES_INIT = 3'(NUM_LIVES);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

   logic [3:0] prev_dpad;
   logic [7:0] hold_cnt;
   logic       press;

   logic [2:0] next_state;
   logic [3:0] next_level;
   logic [2:0] next_lives;
   logic [7:0] next_hold;
   logic       ev;
   logic [1:0] ev_sel;

   // A press is the rising edge of "any direction held", so holding the pad never repeats.
   assign press = (dpad_input != 4'd0) && (prev_dpad == 4'd0);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      next_state = state;
      next_level = level;
      next_lives = lives;
      next_hold  = hold_cnt;
      ev         = 1'b0;
      ev_sel     = SND_UI_PRESS;
      case (state)
         S_MENU: begin
            if (press) begin
               next_state = S_PLAYING;
               next_level = 4'd0;
               next_lives = LIVES_INIT;
               ev         = 1'b1;
               ev_sel     = SND_UI_PRESS;
            end
         end
         S_PLAYING: begin
            if (collision) begin
               next_state = S_DYING;
               next_hold  = 8'd0;
               if (lives != 3'd0) next_lives = lives - 3'd1;
               ev         = 1'b1;
               ev_sel     = SND_CRASH;
            end else if (reached_end) begin
               next_hold = 8'd0;
               ev        = 1'b1;
               if (level == LAST_LEVEL) begin
                  next_state = S_WIN;
                  ev_sel     = SND_CELEBRATION;
               end else begin
                  next_state = S_LEVEL_UP;
                  ev_sel     = SND_NEXTLEVEL;
               end
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            else if (press && dpad_input == 4'b1111) begin
               next_state = S_PAUSED;
            end
`endif
         end
         S_DYING, S_LEVEL_UP: begin
            if (frame_tick) begin
               if (hold_cnt == HOLD_LAST) begin
                  next_hold = 8'd0;
                  if (state == S_DYING) begin
                     next_state = (lives != 3'd0) ? S_PLAYING : S_GAME_OVER;
                  end else begin
                     next_state = S_PLAYING;
                     if (level != LAST_LEVEL) next_level = level + 4'd1;
                  end
               end else begin
                  next_hold = hold_cnt + 8'd1;
               end
            end
         end
         S_GAME_OVER, S_WIN: begin
            // level and lives stay visible on the end screens until the next game starts
            if (press) begin
               next_state = S_MENU;
               ev         = 1'b1;
               ev_sel     = SND_UI_PRESS;
            end
         end
`ifdef GAME_SEQUENCER_PAUSE_EN
         S_PAUSED: begin
            if (press && dpad_input == 4'b1111) next_state = S_PLAYING;
         end
`endif
         default: next_state = S_MENU;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_MENU;
         level           <= 4'd0;
         lives           <= LIVES_INIT;
         win             <= 1'b0;
         lose            <= 1'b0;
         snd.sound_sel   <= SND_UI_PRESS;
         snd.sound_valid <= 1'b0;
         hold_cnt        <= 8'd0;
         prev_dpad       <= 4'd0;
      end else begin
         state     <= next_state;
         level     <= next_level;
         lives     <= next_lives;
         hold_cnt  <= next_hold;
         prev_dpad <= dpad_input;
         win       <= (next_state == S_WIN);
         lose      <= (next_state == S_GAME_OVER);
         // A new event wins over an accept in the same cycle: latest sound stays pending.
         if (ev) begin
            snd.sound_sel   <= ev_sel;
            snd.sound_valid <= 1'b1;
         end else if (snd.sound_valid && snd.sound_ready) begin
            snd.sound_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with default parameters (8 levels, 3 lives, 60 frames).
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic [3:0] dpad_input = 4'd0;
   logic       collision = 1'b0;
   logic       reached_end = 1'b0;
   logic [2:0] state;
   logic [3:0] level;
   logic [2:0] lives;
   logic       win;
   logic       lose;

   int checks = 0;
   int failures = 0;
   int accepts = 0;
   int a0;

   game_sequencer_if sif ();

   game_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .dpad_input  (dpad_input),
      .collision   (collision),
      .reached_end (reached_end),
      .state       (state),
      .level       (level),
      .lives       (lives),
      .win         (win),
      .lose        (lose),
      .snd         (sif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (sif.sound_valid && sif.sound_ready) accepts++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] v);
      dpad_input = v;
      step();
      dpad_input = 4'd0;
   endtask

   task automatic hold(input int n);
      frame_tick = 1'b1;
      for (int i = 0; i < n; i++) step();
      frame_tick = 1'b0;
   endtask

   task automatic ack();
      sif.sound_ready = 1'b1;
      step();
      sif.sound_ready = 1'b0;
   endtask

   initial begin
      sif.sound_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      check("rst_state", state, 0);
      check("rst_level", level, 0);
      check("rst_lives", lives, 3);
      check("rst_valid", sif.sound_valid, 0);
      check("rst_sel", sif.sound_sel, 0);
      check("rst_win_lose", {win, lose}, 0);

      collision = 1'b1;
      step();
      collision = 1'b0;
      check("menu_ignores_collision", state, 0);

      press(4'b0001);
      check("start_state", state, 1);
      check("start_level", level, 0);
      check("start_lives", lives, 3);
      check("start_valid", sif.sound_valid, 1);
      check("start_sel", sif.sound_sel, 0);
      step();
      check("valid_holds", sif.sound_valid, 1);
      ack();
      check("valid_clears", sif.sound_valid, 0);

      // collision beats reached_end
      collision = 1'b1;
      reached_end = 1'b1;
      step();
      collision = 1'b0;
      reached_end = 1'b0;
      check("die1_state", state, 2);
      check("die1_lives", lives, 2);
      check("die1_sel", sif.sound_sel, 2);
      ack();
      hold(59);
      check("die1_hold59", state, 2);
      hold(1);
      check("die1_exit", state, 1);

      collision = 1'b1;
      step();
      collision = 1'b0;
      check("die2_lives", lives, 1);
      hold(60);
      check("die2_exit", state, 1);
      collision = 1'b1;
      step();
      collision = 1'b0;
      check("die3_lives", lives, 0);
      check("die3_state", state, 2);
      hold(60);
      check("gameover_state", state, 4);
      check("gameover_lose", lose, 1);
      check("gameover_win", win, 0);
      check("gameover_lives", lives, 0);
      press(4'b0010);
      check("gameover_to_menu", state, 0);
      check("menu_lose_clear", lose, 0);
      check("menu_lives_held", lives, 0);
      check("menu_sel", sif.sound_sel, 0);
      ack();

      // second game: pending sound overwritten, single accept
      press(4'b0100);
      check("g2_lives", lives, 3);
      check("g2_valid", sif.sound_valid, 1);
      reached_end = 1'b1;
      step();
      reached_end = 1'b0;
      check("lvlup_state", state, 3);
      check("latest_sel", sif.sound_sel, 1);
      check("latest_valid", sif.sound_valid, 1);
      a0 = accepts;
      ack();
      check("one_accept", accepts - a0, 1);
      check("accept_clears", sif.sound_valid, 0);
      hold(60);
      check("lvl1", level, 1);
      reached_end = 1'b1;
      step();
      reached_end = 1'b0;
      hold(60);
      check("lvl2", level, 2);

      // event in the same cycle as an accept keeps the request alive
      collision = 1'b1;
      sif.sound_ready = 1'b1;
      step();
      collision = 1'b0;
      sif.sound_ready = 1'b0;
      check("same_cycle_valid", sif.sound_valid, 1);
      check("same_cycle_sel", sif.sound_sel, 2);
      check("same_cycle_lives", lives, 2);
      hold(60);
      check("respawn_level", level, 2);
      ack();

      for (int i = 2; i < 7; i++) begin
         reached_end = 1'b1;
         step();
         reached_end = 1'b0;
         if (i == 3) check("lvl3_lvlup", state, 3);
         hold(60);
         if (i == 3) check("lvl3_to_4", level, 4);
      end
      check("lvl7", level, 7);
      reached_end = 1'b1;
      step();
      reached_end = 1'b0;
      check("win_state", state, 5);
      check("win_flag", win, 1);
      check("win_sel", sif.sound_sel, 3);
      check("win_level_cap", level, 7);
      collision = 1'b1;
      step();
      collision = 1'b0;
      check("win_ignores_collision", state, 5);
      check("win_lives_kept", lives, 2);
      press(4'b1000);
      check("win_to_menu", state, 0);
      check("menu_win_clear", win, 0);
      check("menu_level_held", level, 7);

      // reset mid-death with a pending sound
      press(4'b0001);
      collision = 1'b1;
      step();
      collision = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_state", state, 0);
      check("midrst_lives", lives, 3);
      check("midrst_valid", sif.sound_valid, 0);
      check("midrst_sel", sif.sound_sel, 0);

      press(4'b0001);
      ack();
      press(4'b1111);
`ifdef GAME_SEQUENCER_PAUSE_EN
      check("pause_enter", state, 6);
      check("pause_no_sound", sif.sound_valid, 0);
      collision = 1'b1;
      reached_end = 1'b1;
      frame_tick = 1'b1;
      step();
      step();
      collision = 1'b0;
      reached_end = 1'b0;
      frame_tick = 1'b0;
      check("pause_ignores", state, 6);
      check("pause_lives", lives, 3);
      press(4'b1111);
      check("pause_exit", state, 1);
      check("unpause_no_sound", sif.sound_valid, 0);
`else
      check("no_pause_state", state, 1);
      check("no_pause_sound", sif.sound_valid, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
